// File: rtl/rot_pkg.sv
// AHB-Lite encodings and state encoding shared by the rotation engine's bus master.
package rot_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_t;

  localparam logic [2:0] HBURST_INCR = 3'b001;
  localparam logic [2:0] HSIZE_BYTE  = 3'd0;
  localparam logic [2:0] HSIZE_HALF  = 3'd1;
  localparam logic [2:0] HSIZE_WORD  = 3'd2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_BURST,
    S_DRAIN,
    S_ERR
  } am_state_t;

  localparam logic [31:0] KB_BOUNDARY_MASK = 32'h0000_03FF;

  // True when an incremented address has just stepped onto a new 1 KB page.
  function automatic logic at_kb_boundary(input logic [31:0] addr);
    return (addr & KB_BOUNDARY_MASK) == 32'h0;
  endfunction

endpackage

// File: rtl/rot_ahb_master.sv
// AHB-Lite INCR burst master: turns one sequencer command into a pipelined
// burst, enforcing the 1 KB boundary, BUSY insertion and two-cycle ERROR.
module rot_ahb_master
  import rot_pkg::*;
#(
  parameter int P_MAX_BEATS = 16,
  parameter int P_DATA_W    = 32
) (
  input  logic                I_AM_HCLK,
  input  logic                I_AM_RESET,
  input  logic                I_AM_CMD_VALID,
  output logic                O_AM_CMD_READY,
  input  logic [31:0]         I_AM_CMD_ADDR,
  input  logic [4:0]          I_AM_CMD_COUNT,
  input  logic [2:0]          I_AM_CMD_SIZE,
  input  logic                I_AM_CMD_WRITE,
  input  logic [P_DATA_W-1:0] I_AM_WDATA,
  input  logic                I_AM_WVALID,
  output logic                O_AM_WREADY,
  output logic [P_DATA_W-1:0] O_AM_RDATA,
  output logic                O_AM_RVALID,
  output logic [31:0]         O_AM_HADDR,
  output logic [1:0]          O_AM_HTRANS,
  output logic                O_AM_HWRITE,
  output logic [2:0]          O_AM_HSIZE,
  output logic [2:0]          O_AM_HBURST,
  output logic [P_DATA_W-1:0] O_AM_HWDATA,
  input  logic [P_DATA_W-1:0] I_AM_HRDATA,
  input  logic                I_AM_HREADY,
  input  logic                I_AM_HRESP,
  output logic                O_AM_BUSY,
  output logic                O_AM_DONE,
  output logic                O_AM_ERROR
);

  am_state_t             state_q, state_d;
  logic [31:0]           addr_q, addr_d;
  logic [2:0]            size_q, size_d;
  logic                  write_q, write_d;
  logic [4:0]            addr_left_q, addr_left_d;
  logic [4:0]            data_left_q, data_left_d;
  logic                  dphase_q, dphase_d;
  logic [P_DATA_W-1:0]   hwdata_q, hwdata_d;
  logic [P_DATA_W-1:0]   rdata_q, rdata_d;
  logic                  rvalid_q, rvalid_d;
  logic                  done_q, done_d;
  logic                  error_q, error_d;
  logic                  ready_q, ready_d;

  htrans_t               htrans;
  logic                  addr_accept;
  logic                  data_ok;
  logic                  data_err;
  logic                  cmd_accept;
  logic                  cmd_illegal;
  logic [31:0]           addr_inc;

  // Bus-facing decode: transfer type and which pipeline stages complete this cycle.
  always_comb begin
    cmd_accept  = ready_q && I_AM_CMD_VALID;
    cmd_illegal = (I_AM_CMD_COUNT == 5'd0) || (int'(I_AM_CMD_COUNT) > P_MAX_BEATS) ||
                  (I_AM_CMD_SIZE > HSIZE_WORD);
    addr_inc    = addr_q + (32'd1 << size_q);

    htrans = HTRANS_IDLE;
    case (state_q)
      S_ADDR:  if (!write_q || I_AM_WVALID) htrans = HTRANS_NONSEQ;
      S_BURST: begin
        if (write_q && !I_AM_WVALID)  htrans = HTRANS_BUSY;
        else if (at_kb_boundary(addr_q)) htrans = HTRANS_NONSEQ;
        else                           htrans = HTRANS_SEQ;
      end
      default: htrans = HTRANS_IDLE;
    endcase

    addr_accept = I_AM_HREADY && ((htrans == HTRANS_NONSEQ) || (htrans == HTRANS_SEQ));
    data_err    = dphase_q && I_AM_HRESP;
    data_ok     = dphase_q && I_AM_HREADY && !I_AM_HRESP;
  end

  // NOTE: every variable gets its default first so no path through this block
  // leaves one unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    size_d      = size_q;
    write_d     = write_q;
    addr_left_d = addr_left_q;
    data_left_d = data_left_q;
    dphase_d    = dphase_q;
    hwdata_d    = hwdata_q;
    rdata_d     = rdata_q;
    rvalid_d    = 1'b0;
    done_d      = 1'b0;
    error_d     = error_q;

    if (addr_accept && addr_left_q != 5'd0) begin
      addr_d      = addr_inc;
      addr_left_d = addr_left_q - 5'd1;
    end
    if (I_AM_HREADY) dphase_d = addr_accept;
    if (addr_accept && write_q) hwdata_d = I_AM_WDATA;
    if (data_ok && !write_q) begin
      rvalid_d = 1'b1;
      rdata_d  = I_AM_HRDATA;
    end
    if (data_ok && data_left_q != 5'd0) data_left_d = data_left_q - 5'd1;

    case (state_q)
      S_IDLE: begin
        if (cmd_accept) begin
          error_d = cmd_illegal;
          if (cmd_illegal) begin
            done_d = 1'b1;
          end else begin
            addr_d      = I_AM_CMD_ADDR;
            size_d      = I_AM_CMD_SIZE;
            write_d     = I_AM_CMD_WRITE;
            addr_left_d = I_AM_CMD_COUNT;
            data_left_d = I_AM_CMD_COUNT;
            state_d     = S_ADDR;
          end
        end
      end
      S_ADDR: begin
        if (addr_accept) state_d = (addr_left_q == 5'd1) ? S_DRAIN : S_BURST;
      end
      S_BURST, S_DRAIN: begin
        // An ERROR response (including the illegal single-cycle form) cancels the rest.
        if (data_err) begin
          state_d = S_ERR;
          done_d  = 1'b1;
          error_d = 1'b1;
        end else if (data_ok && data_left_q == 5'd1) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end else if (state_q == S_BURST && addr_accept && addr_left_q == 5'd1) begin
          state_d = S_DRAIN;
        end
      end
      S_ERR: begin
        dphase_d = 1'b0;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    ready_d = (state_d == S_IDLE) && !done_d;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge I_AM_HCLK or posedge I_AM_RESET) begin
    if (I_AM_RESET) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      size_q      <= '0;
      write_q     <= 1'b0;
      addr_left_q <= '0;
      data_left_q <= '0;
      dphase_q    <= 1'b0;
      hwdata_q    <= '0;
      rdata_q     <= '0;
      rvalid_q    <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
      ready_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      size_q      <= size_d;
      write_q     <= write_d;
      addr_left_q <= addr_left_d;
      data_left_q <= data_left_d;
      dphase_q    <= dphase_d;
      hwdata_q    <= hwdata_d;
      rdata_q     <= rdata_d;
      rvalid_q    <= rvalid_d;
      done_q      <= done_d;
      error_q     <= error_d;
      ready_q     <= ready_d;
    end
  end

  assign O_AM_CMD_READY = ready_q;
  assign O_AM_WREADY    = addr_accept && write_q;
  assign O_AM_RDATA     = rdata_q;
  assign O_AM_RVALID    = rvalid_q;
  assign O_AM_HADDR     = addr_q;
  assign O_AM_HTRANS    = htrans;
  assign O_AM_HWRITE    = write_q;
  assign O_AM_HSIZE     = size_q;
  assign O_AM_HBURST    = HBURST_INCR;
  assign O_AM_HWDATA    = hwdata_q;
  assign O_AM_BUSY      = (state_q != S_IDLE);
  assign O_AM_DONE      = done_q;
  assign O_AM_ERROR     = error_q;

endmodule

// File: tb/tb_rot_ahb_master.sv
// Directed bench for rot_ahb_master: hand-timed reads, writes, wait states,
// 1 KB crossing, ERROR response, mid-burst reset and an illegal command.
module tb_rot_ahb_master;
  import rot_pkg::*;

  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          cmd_valid, cmd_ready, cmd_write;
  logic [31:0]   cmd_addr;
  logic [4:0]    cmd_count;
  logic [2:0]    cmd_size;
  logic [DW-1:0] wdata, rdata, hwdata, hrdata;
  logic          wvalid, wready, rvalid;
  logic [31:0]   haddr;
  logic [1:0]    htrans;
  logic          hwrite, hready, hresp, busy, done, error;
  logic [2:0]    hsize, hburst;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  rot_ahb_master #(.P_MAX_BEATS(16), .P_DATA_W(DW)) dut (
    .I_AM_HCLK(clk), .I_AM_RESET(rst),
    .I_AM_CMD_VALID(cmd_valid), .O_AM_CMD_READY(cmd_ready),
    .I_AM_CMD_ADDR(cmd_addr), .I_AM_CMD_COUNT(cmd_count),
    .I_AM_CMD_SIZE(cmd_size), .I_AM_CMD_WRITE(cmd_write),
    .I_AM_WDATA(wdata), .I_AM_WVALID(wvalid), .O_AM_WREADY(wready),
    .O_AM_RDATA(rdata), .O_AM_RVALID(rvalid),
    .O_AM_HADDR(haddr), .O_AM_HTRANS(htrans), .O_AM_HWRITE(hwrite),
    .O_AM_HSIZE(hsize), .O_AM_HBURST(hburst), .O_AM_HWDATA(hwdata),
    .I_AM_HRDATA(hrdata), .I_AM_HREADY(hready), .I_AM_HRESP(hresp),
    .O_AM_BUSY(busy), .O_AM_DONE(done), .O_AM_ERROR(error)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Present a command for one cycle; the following posedge is the accept edge.
  task automatic issue(input logic [31:0] a, input logic [4:0] n, input logic wr, input string tag);
    @(negedge clk);
    cmd_valid = 1'b1; cmd_addr = a; cmd_count = n; cmd_size = 3'd2; cmd_write = wr;
    hready = 1'b1; hresp = 1'b0;
    #1 check({tag, " ready"}, 32'(cmd_ready), 32'd1);
  endtask

  // Write burst: WVALID drops for two cycles after beat 2.
  logic       t2_wv [1:9] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
  int         t2_wb [1:9] = '{0, 1, 2, 2, 2, 3, 3, 3, 3};
  logic [1:0] t2_ht [1:9] = '{2'b10, 2'b11, 2'b01, 2'b01, 2'b11, 2'b11, 2'b00, 2'b00, 2'b00};
  logic [31:0] t2_ad [1:6] = '{32'h100, 32'h104, 32'h108, 32'h108, 32'h108, 32'h10C};
  // Read burst with three wait states on beat 2's data phase.
  logic       t3_hr [1:10] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
  logic [31:0] t3_ad [1:7] = '{32'h200, 32'h204, 32'h208, 32'h208, 32'h208, 32'h208, 32'h20C};
  logic [31:0] t3_rd [1:10] = '{32'h0, 32'h0, 32'hE2, 32'h0, 32'h0, 32'h0, 32'hE6, 32'hE7, 32'hE8, 32'h0};
  logic [1:0] t4_ht [1:7] = '{2'b10, 2'b11, 2'b10, 2'b11, 2'b11, 2'b11, 2'b00};

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int wr_cnt;
    int done_cnt;
    rst = 1'b1; cmd_valid = 1'b0; cmd_addr = '0; cmd_count = '0; cmd_size = '0;
    cmd_write = 1'b0; wdata = '0; wvalid = 1'b0; hrdata = '0; hready = 1'b1; hresp = 1'b0;

    // Reset state.
    repeat (2) @(negedge clk);
    #1;
    check("rst ready", 32'(cmd_ready), 32'd0);
    check("rst htrans", 32'(htrans), 32'(HTRANS_IDLE));
    check("rst hburst", 32'(hburst), 32'(HBURST_INCR));
    check("rst haddr", haddr, 32'h0);
    check("rst outs", {26'd0, wready, rvalid, busy, done, error, hwrite}, 32'd0);
    @(negedge clk); rst = 1'b0;
    @(negedge clk); #1 check("rel ready", 32'(cmd_ready), 32'd1);

    // T1: 6-beat read, zero waits.
    issue(32'h100, 5'd6, 1'b0, "t1");
    for (int i = 1; i <= 9; i++) begin
      @(negedge clk); cmd_valid = 1'b0; hrdata = 32'hD0 + 32'(i);
      #1;
      check($sformatf("t1 htrans c%0d", i), 32'(htrans),
            32'((i == 1) ? HTRANS_NONSEQ : (i <= 6) ? HTRANS_SEQ : HTRANS_IDLE));
      if (i <= 6) check($sformatf("t1 haddr c%0d", i), haddr, 32'h100 + 32'(4 * (i - 1)));
      check($sformatf("t1 rvalid c%0d", i), 32'(rvalid), 32'(i >= 3 && i <= 8));
      if (i >= 3 && i <= 8) check($sformatf("t1 rdata c%0d", i), rdata, 32'hD0 + 32'(i - 1));
      check($sformatf("t1 done c%0d", i), 32'(done), 32'(i == 8));
      check($sformatf("t1 ready c%0d", i), 32'(cmd_ready), 32'(i == 9));
    end

    // T2: 4-beat write with BUSY insertion.
    issue(32'h100, 5'd4, 1'b1, "t2");
    wr_cnt = 0;
    for (int i = 1; i <= 9; i++) begin
      @(negedge clk); cmd_valid = 1'b0;
      wvalid = t2_wv[i]; wdata = 32'hC0DE_0000 + 32'(t2_wb[i]);
      #1;
      check($sformatf("t2 htrans c%0d", i), 32'(htrans), 32'(t2_ht[i]));
      if (i <= 6) check($sformatf("t2 haddr c%0d", i), haddr, t2_ad[i]);
      check($sformatf("t2 wready c%0d", i), 32'(wready), 32'(i == 1 || i == 2 || i == 5 || i == 6));
      if (wready) wr_cnt++;
      if (i == 2 || i == 3) check($sformatf("t2 hwdata c%0d", i), hwdata, 32'hC0DE_0000 + 32'(i - 2));
      if (i == 6 || i == 7) check($sformatf("t2 hwdata c%0d", i), hwdata, 32'hC0DE_0000 + 32'(i - 4));
      check($sformatf("t2 done c%0d", i), 32'(done), 32'(i == 8));
    end
    wvalid = 1'b0;
    check("t2 wready pulses", 32'(wr_cnt), 32'd4);

    // T3: 4-beat read, three wait states on beat 2.
    issue(32'h200, 5'd4, 1'b0, "t3");
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk); cmd_valid = 1'b0; hready = t3_hr[i]; hrdata = 32'hE0 + 32'(i);
      #1;
      check($sformatf("t3 htrans c%0d", i), 32'(htrans),
            32'((i == 1) ? HTRANS_NONSEQ : (i <= 7) ? HTRANS_SEQ : HTRANS_IDLE));
      if (i <= 7) check($sformatf("t3 haddr c%0d", i), haddr, t3_ad[i]);
      check($sformatf("t3 rvalid c%0d", i), 32'(rvalid), 32'(i == 3 || i == 7 || i == 8 || i == 9));
      if (rvalid) check($sformatf("t3 rdata c%0d", i), rdata, t3_rd[i]);
      check($sformatf("t3 done c%0d", i), 32'(done), 32'(i == 9));
    end

    // T5: 8-beat write, two-cycle ERROR on beat 3's data phase.
    issue(32'h300, 5'd8, 1'b1, "t5");
    wr_cnt = 0; done_cnt = 0;
    for (int i = 1; i <= 7; i++) begin
      @(negedge clk); cmd_valid = 1'b0; wvalid = 1'b1; wdata = 32'hBEEF_0000 + 32'(i);
      hready = (i != 4); hresp = (i == 4 || i == 5);
      #1;
      if (i >= 5) check($sformatf("t5 htrans c%0d", i), 32'(htrans), 32'(HTRANS_IDLE));
      if (i >= 4 && wready) wr_cnt++;
      if (done) done_cnt++;
      check($sformatf("t5 wready c%0d", i), 32'(wready), 32'(i <= 3));
      check($sformatf("t5 error c%0d", i), 32'(error), 32'(i >= 5));
      check($sformatf("t5 done c%0d", i), 32'(done), 32'(i == 5));
      if (i == 6) check("t5 ready after done", 32'(cmd_ready), 32'd1);
    end
    wvalid = 1'b0; hresp = 1'b0; hready = 1'b1;
    check("t5 wready after error", 32'(wr_cnt), 32'd0);
    check("t5 done pulses", 32'(done_cnt), 32'd1);

    // T4: read crossing the 1 KB boundary; ERROR clears on accept.
    issue(32'h3F8, 5'd6, 1'b0, "t4");
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk); cmd_valid = 1'b0;
      #1;
      if (i == 1) check("t4 error cleared", 32'(error), 32'd0);
      if (i <= 7) check($sformatf("t4 htrans c%0d", i), 32'(htrans), 32'(t4_ht[i]));
      if (i <= 6) check($sformatf("t4 haddr c%0d", i), haddr, 32'h3F8 + 32'(4 * (i - 1)));
      check($sformatf("t4 done c%0d", i), 32'(done), 32'(i == 8));
    end

    // T6: reset mid-burst, then an illegal zero-beat command.
    issue(32'h100, 5'd6, 1'b0, "t6");
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk); cmd_valid = 1'b0;
    end
    #1 check("t6 active before rst", 32'(htrans), 32'(HTRANS_SEQ));
    #2 rst = 1'b1;
    #1;
    check("t6 rst htrans", 32'(htrans), 32'(HTRANS_IDLE));
    check("t6 rst haddr", haddr, 32'h0);
    check("t6 rst outs", {26'd0, cmd_ready, rvalid, busy, done, error, hwrite}, 32'd0);
    @(negedge clk);
    #1 check("t6 rst no done", {30'd0, done, cmd_ready}, 32'd0);
    rst = 1'b0;
    issue(32'h100, 5'd0, 1'b0, "t6 illegal");
    for (int i = 1; i <= 2; i++) begin
      @(negedge clk); cmd_valid = 1'b0;
      #1;
      check($sformatf("t6 htrans c%0d", i), 32'(htrans), 32'(HTRANS_IDLE));
      check($sformatf("t6 busy c%0d", i), 32'(busy), 32'd0);
      check($sformatf("t6 error c%0d", i), 32'(error), 32'd1);
      check($sformatf("t6 done c%0d", i), 32'(done), 32'(i == 1));
      check($sformatf("t6 ready c%0d", i), 32'(cmd_ready), 32'(i == 2));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
